// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared state codes, hole coordinates and colours for the mole renderer
// Contents: state_t codes, rgb_t colours, HOLE_X/HOLE_Y centre tables, in_span helper.
package mole_pkg;

   typedef logic [2:0]  state_t;
   typedef logic [11:0] rgb_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_RISE  = 3'd1;
   localparam state_t ST_UP    = 3'd2;
   localparam state_t ST_FALL  = 3'd3;
   localparam state_t ST_FLASH = 3'd4;

   localparam rgb_t MOLE_COLOR = 12'hFFF;
   localparam rgb_t HIT_COLOR  = 12'hF00;
   localparam rgb_t HOLE_COLOR = 12'h420;
   localparam rgb_t BG_COLOR   = 12'h000;

   // Holes 0..4 form the playfield cross; 5..7 are spare slots for larger NUM_HOLES.
   localparam logic [9:0] HOLE_X [0:7] = '{10'd320, 10'd220, 10'd320, 10'd420,
                                           10'd320, 10'd120, 10'd520, 10'd320};
   localparam logic [9:0] HOLE_Y [0:7] = '{10'd120, 10'd220, 10'd220, 10'd220,
                                           10'd320, 10'd320, 10'd320, 10'd420};

   // Half-open interval test on unsigned coordinates: lo <= v < hi.
   function automatic logic in_span(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/mole_stage_renderer_sprite_rom.sv
// rtl/mole_stage_renderer_sprite_rom.sv - combinational 32x64 mole sprite pattern
// Ports: row_i (5-bit sprite row, 0 = top), pattern_o (64-bit row, bit 63 = leftmost column).
module mole_sprite_rom (
   input  logic [4:0]  row_i,
   output logic [63:0] pattern_o
);

   logic [6:0] half_w;
   logic [6:0] col;
   logic       eye;

   // Rounded head widening over the first eight rows, then a straight body,
   // with two dark eye slots cut out of rows 10..13.
   always_comb begin
      pattern_o = '0;
      half_w    = 7'd24;
      col       = '0;
      eye       = 1'b0;
      if (row_i < 5'd8) begin
         half_w = 7'd8 + {3'd0, row_i[2:0], 1'b0};
      end
      for (int c = 0; c < 64; c++) begin
         col = 7'(c);
         eye = (row_i >= 5'd10) && (row_i <= 5'd13) &&
               (((col >= 7'd20) && (col <= 7'd23)) || ((col >= 7'd40) && (col <= 7'd43)));
         if ((col + half_w >= 7'd32) && (col < 7'd32 + half_w) && !eye) begin
            pattern_o[63-c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mole_stage_renderer.sv
// rtl/mole_stage_renderer.sv - whack-a-mole pixel renderer with pop/hit control
// Ports: clk, reset (sync, active-low); frame_tick, pixel_x/pixel_y, video_on from vga_sync;
//        pop_valid/pop_hole/pop_ready and hit_valid/hit_hole from the game controller;
//        hit_ack, miss event pulses; red/green/blue registered colour (1 clk latency).
module mole_stage_renderer
   import mole_pkg::*;
#(
   parameter int NUM_HOLES    = 5,
   parameter int MOLE_W       = 64,
   parameter int MOLE_H       = 32,
   parameter int HOLE_H       = 4,
   parameter int RISE_STEP    = 4,
   parameter int UP_FRAMES    = 30,
   parameter int FLASH_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   input  logic       pop_valid,
   input  logic [2:0] pop_hole,
   output logic       pop_ready,
   input  logic       hit_valid,
   input  logic [2:0] hit_hole,
   output logic       hit_ack,
   output logic       miss,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue
);

   localparam int UT_W = $clog2(UP_FRAMES + 1);
   localparam int FT_W = $clog2(FLASH_FRAMES + 1);

   localparam logic [9:0] HALF_W = 10'(MOLE_W / 2);
   localparam logic [9:0] HALF_H = 10'(MOLE_H / 2);
   localparam logic [9:0] BAND_H = 10'(HOLE_H);
   localparam logic [9:0] STEP   = 10'(RISE_STEP);
   localparam logic [9:0] FULL   = 10'(MOLE_H);
   localparam logic [3:0] NH     = 4'(NUM_HOLES);

   state_t          state_q,   state_d;
   logic [9:0]      reveal_q,  reveal_d;
   logic [UT_W-1:0] up_q,      up_d;
   logic [FT_W-1:0] flash_q,   flash_d;
   logic [2:0]      hole_q,    hole_d;
   logic            hit_ack_q, hit_ack_d;
   logic            miss_q,    miss_d;
   rgb_t            rgb_q,     rgb_d;

   logic            hit_now;
   logic [9:0]      rise_sum;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      reveal_d  = reveal_q;
      up_d      = up_q;
      flash_d   = flash_q;
      hole_d    = hole_q;
      hit_ack_d = 1'b0;
      miss_d    = 1'b0;
      rise_sum  = reveal_q + STEP;

      hit_now = hit_valid && (hit_hole == hole_q) &&
                ((state_q == ST_RISE) || (state_q == ST_UP) || (state_q == ST_FALL));

      case (state_q)
         ST_IDLE: begin
            if (pop_valid && ({1'b0, pop_hole} < NH)) begin
               hole_d   = pop_hole;
               reveal_d = '0;
               state_d  = ST_RISE;
            end
         end

         ST_RISE, ST_UP, ST_FALL: begin
            // A strike pre-empts any frame_tick arriving in the same cycle,
            // including the one that would otherwise expire the up timer.
            if (hit_now) begin
               state_d   = ST_FLASH;
               hit_ack_d = 1'b1;
               flash_d   = FT_W'(FLASH_FRAMES);
               reveal_d  = FULL;
            end else if (frame_tick) begin
               if (state_q == ST_RISE) begin
                  if (rise_sum >= FULL) begin
                     reveal_d = FULL;
                     up_d     = UT_W'(UP_FRAMES);
                     state_d  = ST_UP;
                  end else begin
                     reveal_d = rise_sum;
                  end
               end else if (state_q == ST_UP) begin
                  if (up_q <= UT_W'(1)) begin
                     up_d    = '0;
                     miss_d  = 1'b1;
                     state_d = ST_FALL;
                  end else begin
                     up_d = up_q - UT_W'(1);
                  end
               end else begin
                  if (reveal_q <= STEP) begin
                     reveal_d = '0;
                     state_d  = ST_IDLE;
                  end else begin
                     reveal_d = reveal_q - STEP;
                  end
               end
            end
         end

         ST_FLASH: begin
            if (frame_tick) begin
               if (flash_q <= FT_W'(1)) begin
                  flash_d  = '0;
                  reveal_d = '0;
                  state_d  = ST_IDLE;
               end else begin
                  flash_d = flash_q - FT_W'(1);
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            reveal_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pixel path
   // ------------------------------------------------------------------
   logic [9:0]  spr_left, spr_right, spr_bot, spr_top;
   logic        in_sprite, in_band;
   logic [4:0]  rom_row;
   logic [5:0]  rom_col;
   logic [63:0] rom_pattern;
   logic [9:0]  band_top, band_left, band_right;

   mole_sprite_rom u_rom (
      .row_i     (rom_row),
      .pattern_o (rom_pattern)
   );

   always_comb begin
      spr_left  = HOLE_X[hole_q] - HALF_W;
      spr_right = HOLE_X[hole_q] + HALF_W;
      spr_bot   = HOLE_Y[hole_q] + HALF_H;
      // reveal==0 makes the row interval empty, so IDLE never draws a sprite.
      spr_top   = spr_bot - reveal_q;
      in_sprite = in_span(pixel_x, spr_left, spr_right) &&
                  in_span(pixel_y, spr_top, spr_bot);
      // Offsets are only meaningful when in_sprite; truncation is then exact.
      rom_row   = 5'(pixel_y - spr_top);
      rom_col   = 6'(pixel_x - spr_left);

      in_band    = 1'b0;
      band_top   = '0;
      band_left  = '0;
      band_right = '0;
      for (int h = 0; h < NUM_HOLES; h++) begin
         band_top   = HOLE_Y[h] + HALF_H;
         band_left  = HOLE_X[h] - HALF_W;
         band_right = HOLE_X[h] + HALF_W;
         if (in_span(pixel_x, band_left, band_right) &&
             in_span(pixel_y, band_top, band_top + BAND_H)) begin
            in_band = 1'b1;
         end
      end

      if (!video_on) begin
         rgb_d = '0;
      end else if (in_sprite && rom_pattern[~rom_col]) begin
         // ~rom_col == 63 - offset: column 0 of the box maps to ROM bit 63.
         rgb_d = (state_q == ST_FLASH) ? HIT_COLOR : MOLE_COLOR;
      end else if (in_band) begin
         rgb_d = HOLE_COLOR;
      end else begin
         rgb_d = BG_COLOR;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         reveal_q  <= '0;
         up_q      <= '0;
         flash_q   <= '0;
         hole_q    <= '0;
         hit_ack_q <= 1'b0;
         miss_q    <= 1'b0;
         rgb_q     <= '0;
      end else begin
         state_q   <= state_d;
         reveal_q  <= reveal_d;
         up_q      <= up_d;
         flash_q   <= flash_d;
         hole_q    <= hole_d;
         hit_ack_q <= hit_ack_d;
         miss_q    <= miss_d;
         rgb_q     <= rgb_d;
      end
   end

   assign pop_ready = (state_q == ST_IDLE);
   assign hit_ack   = hit_ack_q;
   assign miss      = miss_q;
   assign red       = rgb_q[11:8];
   assign green     = rgb_q[7:4];
   assign blue      = rgb_q[3:0];

endmodule

// File: tb/tb_mole_stage_renderer.sv
// tb/tb_mole_stage_renderer.sv - directed self-checking bench for mole_stage_renderer
module tb_mole_stage_renderer;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [9:0] pixel_x, pixel_y;
   logic       video_on;
   logic       pop_valid;
   logic [2:0] pop_hole;
   logic       pop_ready;
   logic       hit_valid;
   logic [2:0] hit_hole;
   logic       hit_ack;
   logic       miss;
   logic [3:0] red, green, blue;

   int n_checks = 0;
   int n_err    = 0;
   int miss_cnt = 0;

   mole_stage_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .video_on   (video_on),
      .pop_valid  (pop_valid),
      .pop_hole   (pop_hole),
      .pop_ready  (pop_ready),
      .hit_valid  (hit_valid),
      .hit_hole   (hit_hole),
      .hit_ack    (hit_ack),
      .miss       (miss),
      .red        (red),
      .green      (green),
      .blue       (blue)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (miss) miss_cnt++;
   end

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         step(1);
         frame_tick = 1'b0;
      end
   endtask

   task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic [11:0] exp);
      pixel_x  = x;
      pixel_y  = y;
      video_on = 1'b1;
      step(1);
      check(tag, {red, green, blue}, exp);
   endtask

   task automatic pop(input logic [2:0] h);
      pop_valid = 1'b1;
      pop_hole  = h;
      step(1);
      pop_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; frame_tick = 1'b0; video_on = 1'b1;
      pixel_x = 10'd320; pixel_y = 10'd110;
      pop_valid = 1'b0; pop_hole = '0; hit_valid = 1'b0; hit_hole = '0;

      // Reset during active video
      step(3);
      check("rst_rgb", {red, green, blue}, 12'h000);
      check("rst_pop_ready", 12'(pop_ready), 12'd1);
      check("rst_hit_ack", 12'(hit_ack), 12'd0);
      check("rst_miss", 12'(miss), 12'd0);
      reset = 1'b1;
      step(1);

      // Hole 1: cx=220, box cols 188..251, bottom 236, band 236..239
      pop(3'd1);
      check("pop1_busy", 12'(pop_ready), 12'd0);
      frames(1);
      pix("r0_top_row", 10'd220, 10'd232, 12'hFFF);
      pix("r0_above", 10'd220, 10'd231, 12'h000);
      pix("r0_band", 10'd220, 10'd237, 12'h420);
      pix("r0_row1_col0", 10'd188, 10'd233, 12'h000);
      pix("r0_row3", 10'd220, 10'd235, 12'hFFF);
      pix("band_right_edge", 10'd251, 10'd236, 12'h420);
      pix("band_past_right", 10'd252, 10'd236, 12'h000);
      pix("band_hole0", 10'd320, 10'd138, 12'h420);
      pix("band_hole4_last", 10'd320, 10'd339, 12'h420);
      pix("band_hole4_past", 10'd320, 10'd340, 12'h000);

      frames(7);
      pix("up_top", 10'd220, 10'd204, 12'hFFF);
      pix("up_above", 10'd220, 10'd203, 12'h000);
      pix("up_eye", 10'd208, 10'd214, 12'h000);
      pix("up_beside_eye", 10'd207, 10'd214, 12'hFFF);

      frames(29);
      step(1);
      check("no_miss_early", 12'(miss_cnt), 12'd0);
      frames(1);
      check("miss_pulse", 12'(miss), 12'd1);
      step(1);
      check("miss_one_cycle", 12'(miss), 12'd0);
      frames(7);
      check("fall_busy", 12'(pop_ready), 12'd0);
      frames(1);
      check("fall_idle", 12'(pop_ready), 12'd1);
      step(1);
      check("miss_count", 12'(miss_cnt), 12'd1);

      // Hole 2: wrong-hole strike, then real hit and flash
      pop(3'd2);
      hit_valid = 1'b1; hit_hole = 3'd3;
      step(1);
      check("wrong_hole_ack", 12'(hit_ack), 12'd0);
      hit_hole = 3'd2;
      step(1);
      check("hit_ack", 12'(hit_ack), 12'd1);
      hit_valid = 1'b0;
      step(1);
      check("hit_ack_one_cycle", 12'(hit_ack), 12'd0);
      pix("flash_pixel", 10'd320, 10'd204, 12'hF00);
      frames(7);
      check("flash_busy", 12'(pop_ready), 12'd0);
      pix("flash_pixel_late", 10'd320, 10'd204, 12'h000 | 12'hF00);
      frames(1);
      check("flash_idle", 12'(pop_ready), 12'd1);
      pix("idle_no_sprite", 10'd320, 10'd204, 12'h000);
      hit_valid = 1'b1; hit_hole = 3'd2;
      step(1);
      check("idle_hit_ignored", 12'(hit_ack), 12'd0);
      hit_valid = 1'b0;

      // Out-of-range pops
      pop(3'd6);
      check("pop6_dropped", 12'(pop_ready), 12'd1);
      pop(3'd5);
      check("pop5_dropped", 12'(pop_ready), 12'd1);

      // Hit coinciding with the up-timer expiry tick (hole 0, top row 104)
      pop(3'd0);
      frames(8);
      frames(29);
      frame_tick = 1'b1; hit_valid = 1'b1; hit_hole = 3'd0;
      step(1);
      frame_tick = 1'b0; hit_valid = 1'b0;
      check("expiry_hit_ack", 12'(hit_ack), 12'd1);
      check("expiry_no_miss", 12'(miss), 12'd0);
      step(1);
      check("expiry_no_miss_later", 12'(miss), 12'd0);

      // Output latency and blanking
      pix("lat_bg", 10'd320, 10'd100, 12'h000);
      pixel_y = 10'd104;
      #2;
      check("lat_not_early", {red, green, blue}, 12'h000);
      step(1);
      check("lat_one_clk", {red, green, blue}, 12'hF00);
      video_on = 1'b0;
      step(1);
      check("blank_rgb", {red, green, blue}, 12'h000);
      video_on = 1'b1;
      frames(8);
      check("expiry_flash_idle", 12'(pop_ready), 12'd1);
      step(1);
      check("expiry_miss_count", 12'(miss_cnt), 12'd1);

      // Pop and hit together in IDLE
      pop_valid = 1'b1; pop_hole = 3'd3; hit_valid = 1'b1; hit_hole = 3'd3;
      step(1);
      pop_valid = 1'b0;
      check("pop_hit_no_ack", 12'(hit_ack), 12'd0);
      check("pop_hit_accepted", 12'(pop_ready), 12'd0);
      step(1);
      hit_valid = 1'b0;
      check("rise_hit_ack", 12'(hit_ack), 12'd1);
      frames(8);
      check("final_idle", 12'(pop_ready), 12'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
